// File: rtl/arbitro_mem_if.sv
// Bus bundle between the memory arbiter, its two requesters and the memory port.
//
// Signal groups:
//   boot                              loader owns memory when high
//   cpu_req/we/addr/wdata, cpu_gnt    CPU request channel and grant pulse
//   ldr_req/we/addr/wdata, ldr_gnt    loader request channel and grant pulse
//   cpu_rvalid, ldr_rvalid, rdata     shared read-return path with per-requester strobes
//   owner                             requester of the last grant (0 CPU, 1 loader)
//   mem_addr/wdata/we, mem_rdata      single-port memory, registered read
//
// Modports:
//   slave   the arbiter's view (requests and mem_rdata in, grants/data/memory port out)
//   master  the environment's view (requesters plus memory model)
interface arbitro_mem_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);

  logic              boot;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              owner;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  boot,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid,
    output rdata, owner,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output boot,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid,
    input  rdata, owner,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/arbitro_mem.sv
// Two-requester arbiter/sequencer for the single-port program/data memory.
//
// Requester 0 is the CPU control path, requester 1 the boot loader. One access is in flight at a
// time: IDLE samples requests and grants a winner, ACC drives the memory port for one cycle, and
// RESP (reads only) captures the registered memory output into rdata with the owner's rvalid.
//
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  arbitro_mem_if.slave: boot, cpu_*/ldr_* request channels, grants, rvalids, rdata, owner,
//        and the memory port (mem_addr/mem_wdata/mem_we out, mem_rdata in)
//
// Fairness: while both requesters ask, the CPU wins until the loader has lost MAX_WAIT times in a
// row; the next contested arbitration then goes to the loader.
module arbitro_mem #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  arbitro_mem_if.slave bus
);

  localparam int unsigned     CntW   = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              ldr_gnt_q, ldr_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  // Arbitration decision, only acted upon in StIdle.
  logic ldr_win;
  logic cpu_win;

  always_comb begin
    ldr_win = 1'b0;
    cpu_win = 1'b0;
    if (bus.boot) begin
      ldr_win = bus.ldr_req;
    end else if (bus.cpu_req && bus.ldr_req) begin
      ldr_win = (wait_q == MaxCnt);
      cpu_win = (wait_q != MaxCnt);
    end else begin
      ldr_win = bus.ldr_req;
      cpu_win = bus.cpu_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    cpu_gnt_d    = 1'b0;
    ldr_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    owner_d      = owner_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Loader starvation counter: counts consecutive losses while it is asking.
        if (bus.ldr_req && !ldr_win) begin
          if (wait_q != MaxCnt) begin
            wait_d = wait_q + CntW'(1);
          end
        end else begin
          wait_d = '0;
        end

        if (ldr_win) begin
          ldr_gnt_d   = 1'b1;
          owner_d     = 1'b1;
          mem_addr_d  = bus.ldr_addr;
          mem_wdata_d = bus.ldr_wdata;
          mem_we_d    = bus.ldr_we;
          state_d     = StAcc;
        end else if (cpu_win) begin
          cpu_gnt_d   = 1'b1;
          owner_d     = 1'b0;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          mem_we_d    = bus.cpu_we;
          state_d     = StAcc;
        end
      end

      StAcc: begin
        // mem_we_q still reflects the access being performed this cycle.
        state_d = mem_we_q ? StIdle : StResp;
      end

      StResp: begin
        rdata_d = bus.mem_rdata;
        if (owner_q) begin
          ldr_rvalid_d = 1'b1;
        end else begin
          cpu_rvalid_d = 1'b1;
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      owner_q      <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      owner_q      <= owner_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.ldr_gnt    = ldr_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.owner      = owner_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;

endmodule

// File: tb/tb_arbitro_mem.sv
// Bench for arbitro_mem: directed scenarios with literal expectations, then random traffic.
// A transaction-level model schedules the expected outputs for every cycle; a memory model
// answers the DUT's memory port.
module tb_arbitro_mem;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arbitro_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  arbitro_mem #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Memory environment: write and registered read on clk.
  logic [DW-1:0] mem [128];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // Transaction-level reference model. At each sampling edge it decides the winner from the
  // arbitration rules and schedules the grant window, the memory port values and, for reads,
  // the rvalid window two edges later. Memory contents are tracked in program order.
  logic [DW-1:0] ref_mem [128];
  int            cyc         = 0;
  int            next_sample = 0;
  int            resp_at     = -1;
  int            waits       = 0;
  bit            resp_who;
  logic [DW-1:0] resp_data;
  bit            model_on    = 1'b0;

  logic          e_cpu_gnt, e_ldr_gnt, e_cpu_rv, e_ldr_rv, e_mem_we, e_owner;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  initial begin
    int winner;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        {e_cpu_gnt, e_ldr_gnt, e_cpu_rv, e_ldr_rv, e_mem_we, e_owner} = '0;
        e_addr      = '0;
        e_wdata     = '0;
        e_rdata     = '0;
        next_sample = cyc + 1;
        resp_at     = -1;
        waits       = 0;
        model_on    = 1'b1;
      end else begin
        e_cpu_gnt = 1'b0;
        e_ldr_gnt = 1'b0;
        e_cpu_rv  = 1'b0;
        e_ldr_rv  = 1'b0;
        e_mem_we  = 1'b0;
        if (resp_at == cyc) begin
          e_rdata = resp_data;
          if (resp_who) e_ldr_rv = 1'b1;
          else          e_cpu_rv = 1'b1;
          resp_at = -1;
        end
        if (cyc == next_sample) begin
          winner = -1;
          if (bus.boot) begin
            if (bus.ldr_req) winner = 1;
          end else if (bus.cpu_req && bus.ldr_req) begin
            winner = (waits == MW) ? 1 : 0;
          end else if (bus.cpu_req) begin
            winner = 0;
          end else if (bus.ldr_req) begin
            winner = 1;
          end

          if (bus.ldr_req && winner != 1) waits = (waits < MW) ? waits + 1 : MW;
          else                            waits = 0;

          if (winner < 0) begin
            next_sample = cyc + 1;
          end else begin
            e_owner = (winner == 1);
            if (winner == 1) begin
              e_ldr_gnt = 1'b1;
              e_addr    = bus.ldr_addr;
              e_wdata   = bus.ldr_wdata;
              e_mem_we  = bus.ldr_we;
            end else begin
              e_cpu_gnt = 1'b1;
              e_addr    = bus.cpu_addr;
              e_wdata   = bus.cpu_wdata;
              e_mem_we  = bus.cpu_we;
            end
            if (e_mem_we) begin
              ref_mem[e_addr] = e_wdata;
              next_sample     = cyc + 2;
            end else begin
              resp_at     = cyc + 2;
              resp_who    = (winner == 1);
              resp_data   = ref_mem[e_addr];
              next_sample = cyc + 3;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("cpu_gnt",    {31'd0, bus.cpu_gnt},    {31'd0, e_cpu_gnt});
        chk("ldr_gnt",    {31'd0, bus.ldr_gnt},    {31'd0, e_ldr_gnt});
        chk("cpu_rvalid", {31'd0, bus.cpu_rvalid}, {31'd0, e_cpu_rv});
        chk("ldr_rvalid", {31'd0, bus.ldr_rvalid}, {31'd0, e_ldr_rv});
        chk("mem_we",     {31'd0, bus.mem_we},     {31'd0, e_mem_we});
        chk("owner",      {31'd0, bus.owner},      {31'd0, e_owner});
        chk("mem_addr",   {25'd0, bus.mem_addr},   {25'd0, e_addr});
        chk("mem_wdata",  bus.mem_wdata,           e_wdata);
        chk("rdata",      bus.rdata,               e_rdata);
      end
    end
  end

  int other_gnt = 0;

  // Present one access and hold it until the grant is seen; returns on the grant cycle.
  task automatic issue(input bit who, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bit got = 1'b0;
    if (who) begin
      bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (who ? bus.ldr_gnt : bus.cpu_gnt) got = 1'b1;
      if (who ? bus.cpu_gnt : bus.ldr_gnt) other_gnt++;
    end
    if (who) bus.ldr_req = 1'b0;
    else     bus.cpu_req = 1'b0;
    chk("gnt_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    logic [9:0] order;
    int         n;

    rst           = 1'b1;
    bus.boot      = 1'b0;
    bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req   = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_pulses", {28'd0, bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid, bus.ldr_rvalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: CPU write
    issue(1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    chk("t1_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("t1_mem_addr", {25'd0, bus.mem_addr}, 32'd5);
    chk("t1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_gnt_drop", {31'd0, bus.cpu_gnt}, 32'd0);

    // 2: CPU read back
    issue(1'b0, 1'b0, 7'd5, 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t2_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("t2_ldr_rvalid", {31'd0, bus.ldr_rvalid}, 32'd0);
    repeat (2) @(negedge clk);

    // 3: boot mode, CPU held off
    bus.boot = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'd9; bus.cpu_wdata = 32'h99;
    other_gnt = 0;
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 7'(i), 32'h100 + i);
    chk("t3_cpu_gnt", other_gnt, 32'd0);
    chk("t3_owner", {31'd0, bus.owner}, 32'd1);
    bus.cpu_req = 1'b0;
    bus.boot    = 1'b0;
    repeat (3) @(negedge clk);

    // 4: both held, starvation limit
    bus.cpu_we = 1'b1; bus.cpu_addr = 7'd20; bus.cpu_wdata = 32'hC0C0;
    bus.ldr_we = 1'b1; bus.ldr_addr = 7'd21; bus.ldr_wdata = 32'h1D1D;
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
    order = '0;
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      @(negedge clk);
      if (bus.cpu_gnt) begin
        n++;
      end else if (bus.ldr_gnt) begin
        order[n] = 1'b1;
        n++;
      end
    end
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    chk("t4_count", n, 32'd10);
    chk("t4_order", {22'd0, order}, 32'b10_0001_0000);
    repeat (3) @(negedge clk);

    // 5: reset during the response cycle drops the read
    issue(1'b0, 1'b0, 7'd5, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    chk("t5_rdata", bus.rdata, 32'd0);
    chk("t5_port", {24'd0, bus.mem_addr, bus.mem_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_late_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);

    // 6: loader write then read
    issue(1'b1, 1'b1, 7'd7, 32'd1);
    issue(1'b1, 1'b0, 7'd7, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_ldr_rvalid", {31'd0, bus.ldr_rvalid}, 32'd1);
    chk("t6_rdata", bus.rdata, 32'd1);
    chk("t6_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    repeat (2) @(negedge clk);

    // Random traffic: requesters hold until granted, then pick a new access or go quiet.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) bus.boot = ~bus.boot;
      if (!bus.cpu_req || bus.cpu_gnt) begin
        bus.cpu_req   = ($urandom_range(0, 2) != 0);
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 7'($urandom_range(0, 15));
        bus.cpu_wdata = $urandom;
      end
      if (!bus.ldr_req || bus.ldr_gnt) begin
        bus.ldr_req   = ($urandom_range(0, 2) != 0);
        bus.ldr_we    = 1'($urandom_range(0, 1));
        bus.ldr_addr  = 7'($urandom_range(0, 15));
        bus.ldr_wdata = $urandom;
      end
    end
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
